// File: rtl/router_pkg.sv
// Shared router types: flit format, port and state encodings, and the XY
// routing function used by every input unit.
package router_pkg;

    localparam int unsigned FLIT_DATA_BITS = 16;
    localparam int unsigned COORD_BITS     = FLIT_DATA_BITS / 2;
    localparam int unsigned NUM_OF_FLITS   = 4;
    localparam int unsigned NUM_OF_PORTS   = 5;

    typedef enum logic [1:0] {
        NONE_FLIT = 2'd0,
        HEAD_FLIT = 2'd1,
        BODY_FLIT = 2'd2,
        TAIL_FLIT = 2'd3
    } FLIT_TYPE_t;

    // NONE_PORT is zero so an idle pipeline bus is all-zero.
    typedef enum logic [2:0] {
        NONE_PORT  = 3'd0,
        LOCAL_PORT = 3'd1,
        NORTH_PORT = 3'd2,
        EAST_PORT  = 3'd3,
        SOUTH_PORT = 3'd4,
        WEST_PORT  = 3'd5
    } PORT_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BLOCKED = 2'd2,
        DRAIN   = 2'd3
    } GLOBAL_STATE_t;

    typedef struct packed {
        logic       valid;
        FLIT_TYPE_t flit_type;
    } FLIT_HEADER_t;

    // For head flits data holds {xaddr, yaddr}.
    typedef struct packed {
        FLIT_HEADER_t              head;
        logic [FLIT_DATA_BITS-1:0] data;
    } FLIT_t;

    localparam int unsigned FLIT_SIZE = $bits(FLIT_t);

    typedef struct packed {
        FLIT_t flit;
        PORT_t target_port;
    } router_pipeline_bus_t;

    // Dimension-ordered routing: resolve x first, then y.
    function automatic PORT_t xy_route(input logic [COORD_BITS-1:0] xaddr,
                                       input logic [COORD_BITS-1:0] yaddr,
                                       input logic [COORD_BITS-1:0] cur_x,
                                       input logic [COORD_BITS-1:0] cur_y);
        PORT_t port;
        if (xaddr > cur_x)      port = EAST_PORT;
        else if (xaddr < cur_x) port = WEST_PORT;
        else if (yaddr > cur_y) port = SOUTH_PORT;
        else if (yaddr < cur_y) port = NORTH_PORT;
        else                    port = LOCAL_PORT;
        return port;
    endfunction

endpackage

// File: rtl/router_input_unit_if.sv
// Link-side and switch-side handshake of one router input unit.
interface router_input_unit_if;
    import router_pkg::*;

    FLIT_t                in_flit;
    logic                 in_ready;
    router_pipeline_bus_t out_bus;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output in_flit,
        output out_ready,
        input  in_ready,
        input  out_bus,
        input  out_valid
    );

    modport slave (
        input  in_flit,
        input  out_ready,
        output in_ready,
        output out_bus,
        output out_valid
    );

endinterface

// File: rtl/router_input_unit_flit_fifo.sv
// Flit FIFO with power-of-two depth and naturally wrapping pointers. No bypass:
// a push while full is ignored, a pop while empty is ignored.
module flit_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; empty entries are never presented.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/router_input_unit.sv
// Router input unit: buffers flits from one link, routes the head flit with XY
// routing, holds that route for the whole packet and presents tagged flits to
// the switch. Define ROUTER_INPUT_STATS_EN to add the saturating drop_cnt port.
module router_input_unit
    import router_pkg::*;
#(
    parameter int unsigned            DEPTH    = NUM_OF_FLITS,
    parameter logic [COORD_BITS-1:0]  ROUTER_X = '0,
    parameter logic [COORD_BITS-1:0]  ROUTER_Y = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    router_input_unit_if.slave        bus,
    output logic                      busy,
    output logic                      proto_err
`ifdef ROUTER_INPUT_STATS_EN
    ,
    output logic [7:0]                drop_cnt
`endif
);

    logic                 push, pop, full, empty;
    logic [FLIT_SIZE-1:0] din_raw, front_raw;
    FLIT_t                front;
    logic                 front_is_head, stray_head, drop, out_fire;

    GLOBAL_STATE_t state_q, state_d;
    PORT_t         target_q, target_d;
    logic          head_pending_q, head_pending_d;
    logic          proto_err_q, proto_err_d;

    assign din_raw = bus.in_flit;
    assign front   = FLIT_t'(front_raw);

    flit_fifo #(
        .WIDTH (FLIT_SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din_raw),
        .dout  (front_raw),
        .full  (full),
        .empty (empty)
    );

    // Handshake decode. The packet's own head stays at the front after routing;
    // any other head seen while ACTIVE is stray and is dropped, never presented.
    always_comb begin
        front_is_head = (front.head.flit_type == HEAD_FLIT);
        stray_head    = (state_q == ACTIVE) && !empty && front_is_head && !head_pending_q;
        drop          = !empty && (((state_q == IDLE) && !front_is_head) || stray_head);
        bus.out_valid = (state_q == ACTIVE) && !empty && !stray_head;
        out_fire      = bus.out_valid && bus.out_ready;
        pop           = out_fire || drop;
        push          = bus.in_flit.head.valid && !full;
        bus.in_ready  = !full;
        bus.out_bus.flit        = bus.out_valid ? front : '0;
        bus.out_bus.target_port = bus.out_valid ? target_q : NONE_PORT;
    end

    // Wormhole FSM next-state: lock the route on a head, release on tail pop.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        head_pending_d = head_pending_q;
        proto_err_d    = proto_err_q | drop;
        unique case (state_q)
            IDLE: begin
                if (!empty && front_is_head) begin
                    state_d        = ACTIVE;
                    target_d       = xy_route(front.data[FLIT_DATA_BITS-1:COORD_BITS],
                                              front.data[COORD_BITS-1:0], ROUTER_X, ROUTER_Y);
                    head_pending_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (out_fire) begin
                    head_pending_d = 1'b0;
                    if (front.head.flit_type == TAIL_FLIT) begin
                        state_d  = IDLE;
                        target_d = NONE_PORT;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                target_d = NONE_PORT;
            end
        endcase
    end

    // FSM and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            target_q       <= NONE_PORT;
            head_pending_q <= 1'b0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            head_pending_q <= head_pending_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign busy      = (state_q == ACTIVE);
    assign proto_err = proto_err_q;

`ifdef ROUTER_INPUT_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped flits.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit (ROUTER_X=1, ROUTER_Y=1, DEPTH=4).
// Accepted legal flits are queued with their expected target port; every
// presented flit is compared against the queue front.
module tb_router_input_unit;
    import router_pkg::*;

    typedef struct {
        FLIT_t flit;
        PORT_t target;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy, proto_err;
`ifdef ROUTER_INPUT_STATS_EN
    logic [7:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    router_input_unit_if bus_if ();

    router_input_unit #(
        .DEPTH    (4),
        .ROUTER_X (8'd1),
        .ROUTER_Y (8'd1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .busy      (busy),
        .proto_err (proto_err)
`ifdef ROUTER_INPUT_STATS_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic snap_valid, snap_busy, snap_ready, snap_perr, snap_acc;
    logic [7:0] snap_drop;
    logic cur_expect;
    PORT_t cur_target;
    router_pipeline_bus_t idle_bus;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic FLIT_t mk(input FLIT_TYPE_t t, input logic [15:0] d);
        FLIT_t f;
        f.head.valid     = 1'b1;
        f.head.flit_type = t;
        f.data           = d;
        return f;
    endfunction

    function automatic PORT_t model_route(input int x, input int y);
        if (x > 1) return EAST_PORT;
        if (x < 1) return WEST_PORT;
        if (y > 1) return SOUTH_PORT;
        if (y < 1) return NORTH_PORT;
        return LOCAL_PORT;
    endfunction

    // One clock: sample and score at negedge, advance past posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        snap_valid = bus_if.out_valid;
        snap_busy  = busy;
        snap_ready = bus_if.in_ready;
        snap_perr  = proto_err;
        snap_acc   = bus_if.in_flit.head.valid && bus_if.in_ready;
`ifdef ROUTER_INPUT_STATS_EN
        snap_drop  = drop_cnt;
`else
        snap_drop  = 8'd0;
`endif
        if (bus_if.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", 64'(bus_if.out_valid), 64'd0);
            end else begin
                check("out_flit", 64'(bus_if.out_bus.flit), 64'(sb[0].flit));
                check("out_target", 64'(bus_if.out_bus.target_port), 64'(sb[0].target));
                if (bus_if.out_ready) void'(sb.pop_front());
            end
        end else begin
            check("idle_bus", 64'(bus_if.out_bus), 64'(idle_bus));
        end
        if (snap_acc && cur_expect) begin
            e.flit   = bus_if.in_flit;
            e.target = cur_target;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (snap_acc) bus_if.in_flit = '0;
    endtask

    task automatic send(input FLIT_t f, input logic expect_out, input PORT_t tgt);
        bus_if.in_flit = f;
        cur_expect     = expect_out;
        cur_target     = tgt;
        for (int i = 0; i < 50; i++) begin
            step();
            if (snap_acc) return;
        end
        check("send_timeout", 64'(snap_acc), 64'd1);
        bus_if.in_flit = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            step();
            if (sb.size() == 0 && !snap_busy && !snap_valid) return;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic packet(input int x, input int y);
        PORT_t t;
        t = model_route(x, y);
        send(mk(HEAD_FLIT, {8'(x), 8'(y)}), 1'b1, t);
        send(mk(TAIL_FLIT, 16'hA5A5), 1'b1, t);
        drain();
    endtask

    initial begin
        idle_bus.flit        = '0;
        idle_bus.target_port = NONE_PORT;
        bus_if.in_flit       = '0;
        bus_if.out_ready     = 1'b0;
        cur_expect           = 1'b0;
        cur_target           = NONE_PORT;
        rst                  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        step();
        check("rst_in_ready", 64'(snap_ready), 64'd1);
        check("rst_out_valid", 64'(snap_valid), 64'd0);
        check("rst_busy", 64'(snap_busy), 64'd0);
        check("rst_proto_err", 64'(snap_perr), 64'd0);
`ifdef ROUTER_INPUT_STATS_EN
        check("rst_drop_cnt", 64'(snap_drop), 64'd0);
`endif

        // Four-flit packet to (3,0): head latency and busy release.
        bus_if.out_ready = 1'b1;
        send(mk(HEAD_FLIT, 16'h0300), 1'b1, EAST_PORT);
        send(mk(BODY_FLIT, 16'h1111), 1'b1, EAST_PORT);
        check("lat_c1_valid", 64'(snap_valid), 64'd0);
        check("lat_c1_busy", 64'(snap_busy), 64'd0);
        send(mk(BODY_FLIT, 16'h2222), 1'b1, EAST_PORT);
        check("lat_c2_valid", 64'(snap_valid), 64'd1);
        check("lat_c2_busy", 64'(snap_busy), 64'd1);
        send(mk(TAIL_FLIT, 16'h3333), 1'b1, EAST_PORT);
        step();
        step();
        check("tail_pop_busy", 64'(snap_busy), 64'd1);
        step();
        check("after_tail_busy", 64'(snap_busy), 64'd0);
        check("after_tail_valid", 64'(snap_valid), 64'd0);
        check("pkt1_drained", 64'(sb.size()), 64'd0);

        // Remaining route directions.
        packet(1, 1);
        packet(0, 1);
        packet(1, 2);
        packet(1, 0);

        // Backpressure: fill the FIFO, hold output, then release.
        bus_if.out_ready = 1'b0;
        send(mk(HEAD_FLIT, 16'h0301), 1'b1, EAST_PORT);
        send(mk(BODY_FLIT, 16'h4444), 1'b1, EAST_PORT);
        send(mk(BODY_FLIT, 16'h5555), 1'b1, EAST_PORT);
        send(mk(TAIL_FLIT, 16'h6666), 1'b1, EAST_PORT);
        bus_if.in_flit = mk(HEAD_FLIT, 16'h0001);
        cur_expect     = 1'b1;
        cur_target     = WEST_PORT;
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_in_ready", 64'(snap_ready), 64'd0);
            check("full_no_accept", 64'(snap_acc), 64'd0);
            check("full_held_valid", 64'(snap_valid), 64'd1);
        end
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (snap_acc) break;
        end
        check("fifth_accepted", 64'(snap_acc), 64'd1);
        send(mk(TAIL_FLIT, 16'h7777), 1'b1, WEST_PORT);
        drain();

        // Body without a head is dropped.
        send(mk(BODY_FLIT, 16'hBEEF), 1'b0, NONE_PORT);
        step();
        step();
        check("stray_proto_err", 64'(snap_perr), 64'd1);
        check("stray_busy", 64'(snap_busy), 64'd0);
`ifdef ROUTER_INPUT_STATS_EN
        check("stray_drop_cnt", 64'(snap_drop), 64'd1);
`endif

        // Reset mid-packet discards everything.
        bus_if.out_ready = 1'b0;
        send(mk(HEAD_FLIT, 16'h0201), 1'b1, EAST_PORT);
        send(mk(BODY_FLIT, 16'h8888), 1'b1, EAST_PORT);
        rst = 1'b1;
        step();
        sb.delete();
        rst = 1'b0;
        step();
        check("mid_rst_busy", 64'(snap_busy), 64'd0);
        check("mid_rst_valid", 64'(snap_valid), 64'd0);
        check("mid_rst_target", 64'(bus_if.out_bus.target_port), 64'(NONE_PORT));
        check("mid_rst_proto_err", 64'(snap_perr), 64'd0);
        step();
        check("mid_rst_empty", 64'(snap_valid), 64'd0);
        bus_if.out_ready = 1'b1;
        packet(1, 0);

        // Stray tails; with stats the counter saturates.
`ifdef ROUTER_INPUT_STATS_EN
        for (int i = 0; i < 100; i++) send(mk(TAIL_FLIT, 16'(i)), 1'b0, NONE_PORT);
        step();
        step();
        check("drop_cnt_100", 64'(snap_drop), 64'd100);
        for (int i = 0; i < 200; i++) send(mk(TAIL_FLIT, 16'(i)), 1'b0, NONE_PORT);
        step();
        step();
        check("drop_cnt_sat", 64'(snap_drop), 64'd255);
`else
        for (int i = 0; i < 3; i++) send(mk(TAIL_FLIT, 16'(i)), 1'b0, NONE_PORT);
        step();
        step();
`endif
        check("tails_proto_err", 64'(snap_perr), 64'd1);
        check("tails_no_valid", 64'(snap_valid), 64'd0);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_input_unit.md
# router_input_unit

Per-port input stage of the mesh router. It accepts flits from one link (or the local NI) into a small FIFO and computes the XY route from the head flit. It locks that route for the packet (wormhole) and presents each flit tagged with its target port on a `router_pipeline_bus_t` to the switch stage. One instance exists per input port (`NUM_OF_PORTS` per router).

## Interface
Parameters:
- `DEPTH`, 4 (`NUM_OF_FLITS`): FIFO depth in flits, power of two, ≥2.
- `ROUTER_X`, 0: this router's x coordinate (8 bits, `FLIT_DATA_BITS/2`).
- `ROUTER_Y`, 0: this router's y coordinate (8 bits).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_flit`  in  `FLIT_SIZE` (`FLIT_t`): incoming flit. `in_flit.head.valid` is the write strobe.
- `in_ready`  out  1: FIFO not full. A flit is accepted when valid && `in_ready`.
- `out_bus`  out  `$bits(router_pipeline_bus_t)`: flit at the FIFO front plus its locked `target_port`.
- `out_valid`  out  1: `out_bus` holds a routed flit.
- `out_ready`  in  1: the switch consumes the flit. Pop occurs when `out_valid` && `out_ready`.
- `busy`  out  1: a route is locked (state ACTIVE).
- `proto_err`  out  1: sticky, set on a dropped illegal flit; cleared only by `rst`.

## Operation
- FIFO: `DEPTH` entries, read/write pointers of width `$clog2(DEPTH)` that wrap naturally. Count is `$clog2(DEPTH)+1` bits.
- Push and pop may occur in the same cycle at any level except full, where `in_ready`=0 and no push is accepted (no bypass).
- A write while full is impossible by protocol. If valid arrives with `in_ready`=0, the flit is ignored and the upstream holds it.
- FSM states are taken from `GLOBAL_STATE_t`; only IDLE and ACTIVE are used.
  - IDLE, front is HEAD_FLIT: compute the route, register `target_port`, go to ACTIVE. The head is not popped this cycle.
  - IDLE, front is BODY/TAIL/NONE: pop it (drop), set `proto_err`, stay IDLE.
  - ACTIVE: `out_valid` = FIFO non-empty. On a pop of TAIL_FLIT, go to IDLE and set `target_port` to NONE_PORT.
  - ACTIVE, front is HEAD_FLIT: treat as a protocol error. Drop it, set `proto_err`, stay ACTIVE.
- XY route, with unsigned 8-bit compares of head `xaddr`/`yaddr` against `ROUTER_X`/`ROUTER_Y`:
  - x > X → EAST_PORT; x < X → WEST_PORT.
  - Otherwise y > Y → SOUTH_PORT; y < Y → NORTH_PORT.
  - Otherwise LOCAL_PORT.
- `out_bus.flit` = FIFO front when `out_valid`, else all-zero. `out_bus.target_port` = locked route when `out_valid`, else NONE_PORT.

## Timing
- Reset values: FIFO empty, state IDLE, `in_ready`=1 from the first cycle after `rst` deasserts. `out_valid`=0, `out_bus`=0 with `target_port`=NONE_PORT, `busy`=0, `proto_err`=0.
- Head latency: head accepted in cycle 0; routed in cycle 1 (IDLE→ACTIVE); `out_valid`=1 in cycle 2.
- Body/tail latency: 1 cycle from acceptance to `out_valid`, if the FIFO front is reached.
- Throughput is 1 flit/cycle within a packet. Each new packet costs one routing bubble after its tail.
- `out_valid` and `out_bus` are stable while `out_valid` && !`out_ready` (backpressure hold).
- `rst` mid-packet: all state is discarded at that edge, and the partially stored packet is lost.

## Configuration
- `ROUTER_INPUT_STATS_EN`.
- Defined: adds output port `drop_cnt`, 8 bits. It is a saturating count of dropped flits (stops at 255), reset to 0.
- Undefined: the port and counter do not exist; `proto_err` behaviour is unchanged.

## Structure
- `router_pkg` supplies `FLIT_t`, `FLIT_TYPE_t`, `PORT_t`, `GLOBAL_STATE_t`, `router_pipeline_bus_t`, `FLIT_SIZE`, and `FLIT_DATA_BITS`.
- Add to `router_pkg`: a function `xy_route(xaddr, yaddr, cur_x, cur_y)` returning `PORT_t`, so it is shared by all ports.
- Sub-module `flit_fifo` (params `WIDTH`, `DEPTH`; ports `push`, `pop`, `din`, `dout`, `full`, `empty`). FSM and routing live in `router_input_unit`.

## Test plan
- `ROUTER_X`=1, `ROUTER_Y`=1; head x=3,y=0, two bodies, tail, `out_ready`=1 → head appears with `out_valid` 2 cycles after accept, target EAST_PORT. Four flits arrive in order, then `busy`=0 one cycle after the tail pop.
- Heads to (1,1), (0,1), (1,2), (1,0) each followed by tail → target_port LOCAL, WEST, SOUTH, NORTH respectively.
- `out_ready`=0, push 5 flits, `DEPTH`=4 → `in_ready`=0 after 4 accepts and `out_bus` is held. Release `out_ready` → all 4 drain in order and the 5th is then accepted.
- Body flit with no preceding head → dropped, `proto_err`=1, `out_valid` never asserted. With `ROUTER_INPUT_STATS_EN`, `drop_cnt`=1.
- `rst` asserted after head+body accepted → next cycle FIFO is empty, `busy`=0, `target_port`=NONE_PORT. A following clean packet routes correctly.
- 300 stray tails with `ROUTER_INPUT_STATS_EN` → `drop_cnt` saturates at 255.
